// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator command sequencer.
package accum_pkg;

   // Operand slots held by the downstream accumulator.
   localparam int unsigned MAX_SLOTS = 3;

   // Step tag width; matches the accumulator program-counter input.
   localparam int unsigned DEF_TAG_W = 12;

   typedef logic [1:0] arity_t;

   // Sequencer states; kept as plain constants for compatibility with older tooling.
   typedef logic [1:0] state_t;
   localparam state_t IDLE      = 2'd0;
   localparam state_t FILL      = 2'd1;
   localparam state_t WAIT_OPND = 2'd2;
   localparam state_t FIRE      = 2'd3;

endpackage

// File: rtl/accum_sequencer_if.sv
// Requester and accumulator-side signal bundle for the command sequencer.
interface accum_sequencer_if #(
   parameter int unsigned TAG_W = accum_pkg::DEF_TAG_W
);
   import accum_pkg::*;

   logic [1:0]       put_valid;
   logic [1:0][7:0]  put_data;
   logic [1:0]       put_ready;
   logic             op_valid;
   arity_t           op_arity;
   logic             op_ready;
   logic             op_done;
   logic             err_clr;
   logic             err_arity;
   logic             err_timeout;
   logic [1:0]       occupancy;
   logic             acc_put_en;
   logic             acc_op_en;
   logic [7:0]       acc_value;
   logic [TAG_W-1:0] acc_tag;

   // Requester / environment side.
   modport master (
      output put_valid, put_data, op_valid, op_arity, err_clr,
      input  put_ready, op_ready, op_done, err_arity, err_timeout, occupancy,
      input  acc_put_en, acc_op_en, acc_value, acc_tag
   );

   // Sequencer side.
   modport slave (
      input  put_valid, put_data, op_valid, op_arity, err_clr,
      output put_ready, op_ready, op_done, err_arity, err_timeout, occupancy,
      output acc_put_en, acc_op_en, acc_value, acc_tag
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the preferred port flips after every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic prio_q;  // port that wins when both request

   // Resolve contention by the priority pointer; a lone requester always wins.
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = prio_q ? 2'b10 : 2'b01;
      end
   end

   // Flip preference on each transfer; reset favours port 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else if (advance) begin
         prio_q <= ~prio_q;
      end
   end

endmodule

// File: rtl/accum_sequencer.sv
// Arbitrates operand puts and fires ops into the 3-slot accumulator, one tagged
// command per cycle.
module accum_sequencer
   import accum_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned TAG_W   = DEF_TAG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   accum_sequencer_if.slave   bus
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [1:0]         occ_q, occ_d;
   arity_t             arity_q, arity_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [7:0]         value_q, value_d;
   logic               put_en_q, op_en_q;
   logic               err_arity_q, err_arity_d;
   logic               err_timeout_q, err_timeout_d;

   logic       op_take, arity_zero, fire_on_accept, fire_from_wait, go_fire;
   logic       room, put_take, timeout_hit;
   logic [1:0] req, grant;

   // Op acceptance and the decision to fire this cycle.
   always_comb begin
      op_take        = bus.op_valid && (state_q != WAIT_OPND) && (state_q != FIRE);
      arity_zero     = (bus.op_arity == 2'd0);
      fire_on_accept = op_take && !arity_zero && (occ_q >= bus.op_arity);
      fire_from_wait = (state_q == WAIT_OPND) && (occ_q >= arity_q);
      go_fire        = fire_on_accept || fire_from_wait;
      // No put may share a cycle with a command heading to FIRE.
      room           = (occ_q < 2'(MAX_SLOTS)) && (state_q != FIRE) && !go_fire;
      req            = bus.put_valid & {2{room}};
   end

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (put_take),
      .grant   (grant)
   );

   assign put_take    = |grant;
   assign timeout_hit = (state_q == WAIT_OPND) && !fire_from_wait && !put_take &&
                        (wait_q == WAIT_W'(TIMEOUT - 1));

   // Next state, occupancy, wait counter, tag and command fields.
   always_comb begin
      state_d  = state_q;
      occ_d    = put_take ? occ_q + 2'd1 : occ_q;
      arity_d  = (op_take && !arity_zero) ? bus.op_arity : arity_q;
      wait_d   = '0;
      if (go_fire) begin
         state_d = FIRE;
         occ_d   = '0;  // accumulator drops every slot, excess operands included
      end else begin
         case (state_q)
            FIRE: begin
               state_d = IDLE;
            end
            WAIT_OPND: begin
               if (timeout_hit) begin
                  state_d = (occ_d != 2'd0) ? FILL : IDLE;
               end else begin
                  wait_d = put_take ? '0 : wait_q + WAIT_W'(1);
               end
            end
            default: begin
               if (op_take && !arity_zero) begin
                  state_d = WAIT_OPND;
               end else begin
                  state_d = (occ_d != 2'd0) ? FILL : IDLE;
               end
            end
         endcase
      end
      tag_d         = (put_take || go_fire) ? tag_q + TAG_W'(1) : tag_q;
      value_d       = put_take ? (grant[1] ? bus.put_data[1] : bus.put_data[0]) : value_q;
      // A set event beats a simultaneous clear.
      err_arity_d   = (op_take && arity_zero) || (err_arity_q && !bus.err_clr);
      err_timeout_d = timeout_hit || (err_timeout_q && !bus.err_clr);
   end

   // Register all state and every accumulator-facing output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         occ_q         <= '0;
         arity_q       <= '0;
         wait_q        <= '0;
         tag_q         <= '0;
         value_q       <= '0;
         put_en_q      <= 1'b0;
         op_en_q       <= 1'b0;
         err_arity_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         occ_q         <= occ_d;
         arity_q       <= arity_d;
         wait_q        <= wait_d;
         tag_q         <= tag_d;
         value_q       <= value_d;
         put_en_q      <= put_take;
         op_en_q       <= go_fire;
         err_arity_q   <= err_arity_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus.put_ready   = grant;
   assign bus.op_ready    = op_take;
   assign bus.op_done     = op_en_q;
   assign bus.err_arity   = err_arity_q;
   assign bus.err_timeout = err_timeout_q;
   assign bus.occupancy   = occ_q;
   assign bus.acc_put_en  = put_en_q;
   assign bus.acc_op_en   = op_en_q;
   assign bus.acc_value   = value_q;
   assign bus.acc_tag     = tag_q;

endmodule
